serial_divider: RTL and testbench
=================================

Name: serial_divider

Overview:
- Sequential restoring divider that inverts the 4x4 array multiplier: takes a 2N-bit product-width dividend and an N-bit divisor, and returns an N-bit quotient and an N-bit remainder.
- Produces one quotient bit per clock, under a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath; a multiply followed by this divide must round-trip.

Parameters:
- N, 4, divisor/quotient/remainder width; dividend width is 2N.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- dividend  input  2N  dividend p; sampled on the accepted start.
- divisor  input  N  divisor b; sampled on the accepted start.
- quotient  output  N  result q; valid while done=1, held until next accepted start.
- remainder  output  N  result r; same validity as quotient.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse when results become valid.
- ovf  output  1  quotient does not fit in N bits; valid with done.
- dbz  output  1  divisor was zero; valid with done.

Behaviour:
- Reset (rst=1 at an edge) forces state=IDLE.
- Reset clears quotient, remainder, busy, done, ovf, dbz and the step counter to 0.
- Reset wins over every other event, including mid-CALC; the aborted operation produces no done.
- States: IDLE, CALC, DONE.
- IDLE:
  - On start=1, latch the operands.
  - Clear ovf/dbz.
  - If divisor==0: dbz<=1, quotient<=all ones, remainder<=dividend[N-1:0], go to DONE.
  - Else if dividend[2N-1:N] >= divisor: ovf<=1, quotient<=all ones, remainder<=0, go to DONE.
  - Else: partial remainder R (N+1 bits) <= {0,dividend[2N-1:N]}, shift register Q <= dividend[N-1:0], counter<=0, go to CALC.
  - start=0 keeps the state at IDLE.
- CALC, one step per cycle:
  - T = {R[N-1:0],Q[N-1]} - {0,divisor}, computed N+1 bits wide.
  - If T is non-negative: R<=T and Q<={Q[N-2:0],1}.
  - Otherwise: R<={R[N-1:0],Q[N-1]} and Q<={Q[N-2:0],0}.
  - counter increments; after the step with counter==N-1, go to DONE.
  - Exactly N CALC cycles.
- DONE:
  - done=1 for exactly one cycle.
  - quotient=Q and remainder=R[N-1:0], or the error values on the error paths.
  - Next state is always IDLE; start in DONE is ignored.
- busy=1 in CALC and DONE; busy=0 in IDLE.
- start while busy=1 is ignored. It is not queued, and the operands in flight are not disturbed.
- Latency from the start-sampling edge to done high:
  - Normal path: N+1 cycles.
  - Error paths: 1 cycle.
- Back-to-back: start may be accepted in the first IDLE cycle after DONE.
  - Minimum issue interval for normal operations is N+2 cycles.
- Invariant on the normal path: dividend == quotient*divisor + remainder, with remainder < divisor.
- Outputs hold their last values in IDLE until the next accepted start; ovf/dbz clear at that acceptance.

Decomposition:
- Shared package holds:
  - state encoding constants S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2;
  - default width N=4.
- One natural sub-module: ripple_subtractor, (N+1)-bit, built from the existing full_adder with inverted subtrahend and carry-in=1. Its carry-out=1 means the trial result is non-negative.
- Control FSM and shift registers live in the top module.

Test Plan:
1. Normal division, case A:
   - reset, then start with dividend=0x8F (143), divisor=0xD.
   - Expect done 5 cycles later, quotient=0xB, remainder=0x0, ovf=0, dbz=0.
2. Normal division, case B:
   - dividend=0xC8 (200), divisor=0xF.
   - Expect quotient=0xD, remainder=0x5.
   - Then dividend=0xE1, divisor=0xF, issued back-to-back in the first IDLE cycle.
   - Expect quotient=0xF, remainder=0x0.
3. Error paths:
   - dividend=0xF0, divisor=0xF: done 1 cycle later, ovf=1, quotient=0xF, remainder=0.
   - dividend=0x37, divisor=0x0: dbz=1, quotient=0xF, remainder=0x7.
4. start held high through CALC with different operands:
   - Expect a single done carrying the first operation's results.
   - Expect no second operation to start until IDLE.
5. Reset mid-operation:
   - rst=1 at the third CALC cycle.
   - Expect all outputs 0, no done pulse, and IDLE on the next cycle.
   - A fresh start with 0x8F/0xD still gives 0xB/0x0.
6. Exhaustive round-trip:
   - For all a,b in 1..15, feed dividend=a*b and divisor=b.
   - Expect quotient=a, remainder=0, ovf=0.
   - For all 2N-bit/N-bit pairs, check the invariant or the correct error flag.

Source files
------------

// File: rtl/serial_divider_pkg.sv
// Shared types and constants for the serial divider slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_divider_pkg;

    // Default divisor/quotient/remainder width; dividend is twice this.
    localparam int unsigned DEF_N = 4;

    // Control FSM encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_divider_if.sv
// Operand/result bundle between a requester and the serial divider.
// Latency: n/a (wiring only).
// Backpressure: start is only honoured while busy is low; no queueing.
interface serial_divider_if
    import serial_divider_pkg::*;
#(
    parameter int N = DEF_N
);
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           busy;
    logic           done;
    logic           ovf;
    logic           dbz;

    // Requester side: issues operands, observes results.
    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, ovf, dbz
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, ovf, dbz
    );
endinterface

// File: rtl/serial_divider_ripple_subtractor.sv
// (W)-bit ripple subtractor a - b built from full adders (b inverted, carry-in 1).
// Latency: combinational.
// Backpressure: none; cout_o=1 means a >= b (no borrow).
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module ripple_subtractor #(
    parameter int W = 5
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         cout_o
);
    logic [W:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (~b_i[i]),
            .c_i (carry[i]),
            .s_o (diff_o[i]),
            .c_o (carry[i+1])
        );
    end

    assign cout_o = carry[W];
endmodule

// File: rtl/serial_divider.sv
// Restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// Latency: N+1 cycles start->done on the normal path, 1 cycle on overflow/divide-by-zero.
// Backpressure: start is ignored while busy (CALC/DONE); not queued.
module serial_divider
    import serial_divider_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic             clk,
    input  logic             rst,
    serial_divider_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t         state_q, state_d;
    logic [N:0]     r_q, r_d;          // partial remainder
    logic [N-1:0]   q_q, q_d;          // dividend low half shifting out, quotient shifting in
    logic [N-1:0]   dvs_q, dvs_d;      // divisor captured at acceptance
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           ovf_q, ovf_d;
    logic           dbz_q, dbz_d;

    logic [N:0]     shifted;
    logic [N:0]     trial;
    logic           trial_ok;

    // R cannot exceed the divisor, so dropping its top bit on the shift loses nothing.
    assign shifted = {r_q[N-1:0], q_q[N-1]};

    ripple_subtractor #(.W(N+1)) u_sub (
        .a_i    (shifted),
        .b_i    ({1'b0, dvs_q}),
        .diff_o (trial),
        .cout_o (trial_ok)
    );

    // Next-state and datapath updates for the IDLE/CALC/DONE controller.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    ovf_d = 1'b0;
                    dbz_d = 1'b0;
                    dvs_d = bus.divisor;
                    if (bus.divisor == '0) begin
                        dbz_d   = 1'b1;
                        quo_d   = '1;
                        rem_d   = bus.dividend[N-1:0];
                        state_d = S_DONE;
                    end else if (bus.dividend[2*N-1:N] >= bus.divisor) begin
                        ovf_d   = 1'b1;
                        quo_d   = '1;
                        rem_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        r_d     = {1'b0, bus.dividend[2*N-1:N]};
                        q_d     = bus.dividend[N-1:0];
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (trial_ok) begin
                    r_d = trial;
                    q_d = {q_q[N-2:0], 1'b1};
                end else begin
                    r_d = shifted;
                    q_d = {q_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N-1)) begin
                    quo_d   = q_d;
                    rem_d   = r_d[N-1:0];
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbz       = dbz_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_divider.sv
// Directed and exhaustive checks of the serial divider against hand/arith expectations.
// Latency: checks N+1 normal and 1-cycle error latency.
// Backpressure: exercises start held/issued while busy.
module tb_serial_divider;

    logic clk;
    logic rst;
    int   chk;
    int   err;

    serial_divider_if #(.N(4)) bus ();

    serial_divider #(.N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] p;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       ovf;
        logic       dbz;
        int         lat;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Steps until done, with a cycle bound; lat counts from the acceptance edge.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat <= 20) begin
            step();
            lat++;
        end
        if (!bus.done) begin
            chk++;
            err++;
            $display("FAIL timeout waiting for done got=0 exp=1");
        end
    endtask

    task automatic run_op(input logic [7:0] p, input logic [3:0] b,
                          output int lat, output logic busy1);
        bus.start    = 1'b1;
        bus.dividend = p;
        bus.divisor  = b;
        step();
        bus.start = 1'b0;
        busy1 = bus.busy;
        wait_done(lat);
    endtask

    initial begin
        int         lat;
        logic       busy1;
        int         dones;
        logic [3:0] eq, er;
        logic       eo, ez;
        logic [7:0] p;
        logic [3:0] b;

        chk = 0;
        err = 0;
        vecs[0] = '{8'h8F, 4'hD, 4'hB, 4'h0, 1'b0, 1'b0, 5};
        vecs[1] = '{8'hC8, 4'hF, 4'hD, 4'h5, 1'b0, 1'b0, 5};
        vecs[2] = '{8'hE1, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 5};
        vecs[3] = '{8'hF0, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 1};
        vecs[4] = '{8'h37, 4'h0, 4'hF, 4'h7, 1'b0, 1'b1, 1};
        vecs[5] = '{8'h00, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 5};
        vecs[6] = '{8'hEF, 4'hF, 4'hF, 4'hE, 1'b0, 1'b0, 5};
        vecs[7] = '{8'h0F, 4'h1, 4'hF, 4'h0, 1'b0, 1'b0, 5};
        vecs[8] = '{8'h10, 4'h1, 4'hF, 4'h0, 1'b1, 1'b0, 1};
        vecs[9] = '{8'h64, 4'h7, 4'hE, 4'h2, 1'b0, 1'b0, 5};

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset outputs", {bus.quotient, bus.remainder, bus.busy, bus.done, bus.ovf, bus.dbz}, 0);

        // Table-driven directed vectors.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].p, vecs[i].b, lat, busy1);
            check($sformatf("vec%0d busy", i), busy1, 1);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d q", i), bus.quotient, vecs[i].q);
            check($sformatf("vec%0d r", i), bus.remainder, vecs[i].r);
            check($sformatf("vec%0d ovf", i), bus.ovf, vecs[i].ovf);
            check($sformatf("vec%0d dbz", i), bus.dbz, vecs[i].dbz);
            step();
        end

        // Back-to-back: start raised during DONE is ignored, accepted in the first IDLE cycle.
        run_op(8'hC8, 4'hF, lat, busy1);
        check("b2b first q/r", {bus.quotient, bus.remainder}, 8'hD5);
        bus.start    = 1'b1;
        bus.dividend = 8'hE1;
        bus.divisor  = 4'hF;
        step();
        check("b2b start in DONE ignored", {bus.busy, bus.done}, 2'b00);
        step();
        bus.start = 1'b0;
        check("b2b accepted in IDLE", bus.busy, 1);
        wait_done(lat);
        check("b2b second latency", lat, 5);
        check("b2b second q/r", {bus.quotient, bus.remainder, bus.ovf}, 9'h1E0);
        step();

        // start held high with changing operands while busy.
        bus.start    = 1'b1;
        bus.dividend = 8'h8F;
        bus.divisor  = 4'hD;
        step();
        bus.dividend = 8'hC8;
        bus.divisor  = 4'hF;
        wait_done(lat);
        check("held start latency", lat, 5);
        check("held start q/r", {bus.quotient, bus.remainder}, 8'hB0);
        step();
        check("held start no restart from DONE", {bus.busy, bus.done}, 2'b00);
        bus.start = 1'b0;
        step();
        check("held start idle after drop", bus.busy, 0);

        // Reset during the third CALC cycle.
        run_op(8'hEF, 4'hF, lat, busy1);
        step();
        bus.start    = 1'b1;
        bus.dividend = 8'h8F;
        bus.divisor  = 4'hD;
        step();
        bus.start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid-op reset outputs", {bus.quotient, bus.remainder, bus.busy, bus.done, bus.ovf, bus.dbz}, 0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done) dones++;
            step();
        end
        check("mid-op reset no done", dones, 0);
        run_op(8'h8F, 4'hD, lat, busy1);
        check("post-reset latency", lat, 5);
        check("post-reset q/r", {bus.quotient, bus.remainder}, 8'hB0);
        step();

        // Multiply round-trip for all nonzero 4-bit factors.
        for (int a = 1; a < 16; a++) begin
            for (int bb = 1; bb < 16; bb++) begin
                run_op(8'(a * bb), 4'(bb), lat, busy1);
                check($sformatf("roundtrip %0d*%0d", a, bb),
                      {bus.quotient, bus.remainder, bus.ovf, bus.dbz}, {4'(a), 4'h0, 2'b00});
                step();
            end
        end

        // Every dividend/divisor pair against an arithmetic reference.
        for (int pi = 0; pi < 256; pi++) begin
            for (int bi = 0; bi < 16; bi++) begin
                p = 8'(pi);
                b = 4'(bi);
                if (bi == 0) begin
                    eq = 4'hF; er = p[3:0]; eo = 1'b0; ez = 1'b1;
                end else if ((pi / 16) >= bi) begin
                    eq = 4'hF; er = 4'h0; eo = 1'b1; ez = 1'b0;
                end else begin
                    eq = 4'(pi / bi); er = 4'(pi % bi); eo = 1'b0; ez = 1'b0;
                end
                run_op(p, b, lat, busy1);
                check($sformatf("exh p=%0h b=%0h", p, b),
                      {bus.quotient, bus.remainder, bus.ovf, bus.dbz}, {eq, er, eo, ez});
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
